// File: rtl/clint_pkg.sv
// Shared address map, CTRL bit positions and reset constants for the multi-hart CLINT.
package clint_pkg;

    localparam int unsigned OFF_PRESC    = 0;
    localparam int unsigned OFF_MTIME_LO = 1;
    localparam int unsigned OFF_MTIME_HI = 2;
    localparam int unsigned OFF_CTRL     = 3;
    localparam int unsigned HART_BASE    = 4;
    localparam int unsigned HART_STRIDE  = 4;

    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_CLR_PRESC = 1;

    localparam logic [63:0] CMP_RST = '1;

    // Word offsets inside one hart block; values match addr[1:0] because blocks are 4-aligned.
    typedef enum logic [1:0] {
        HREG_CMP_LO = 2'd0,
        HREG_CMP_HI = 2'd1,
        HREG_MSIP   = 2'd2,
        HREG_STATUS = 2'd3
    } hart_reg_e;

    function automatic int unsigned map_words(input int unsigned n_harts);
        return HART_BASE + HART_STRIDE * n_harts;
    endfunction

endpackage

// File: rtl/clint_hart_cmp.sv
// Per-hart MTIMECMP/MSIP registers with the registered timer compare.
module clint_hart_cmp
    import clint_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] mtime,
    input  logic        en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_msip,
    input  logic [31:0] wdata,
    output logic [63:0] cmp,
    output logic        mtip,
    output logic        msip
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp  <= CMP_RST;
            mtip <= 1'b0;
            msip <= 1'b0;
        end else begin
            if (wr_lo) cmp[31:0]  <= wdata;
            if (wr_hi) cmp[63:32] <= wdata;
            if (wr_msip) msip <= wdata[0];
            mtip <= en & (mtime >= cmp);
        end
    end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: bus decode, prescaler, shared MTIME and read mux; per-hart compare in clint_hart_cmp.
// Option: define CLINT_MTIME_SNAP_EN to return a snapshot of MTIME_HI taken on each MTIME_LO read.
module clint_mh
    import clint_pkg::*;
#(
    parameter int unsigned N_HARTS = 2,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned PRESC_W = 16
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_H_rd_L,
    input  logic               req,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               rvalid,
    output logic               bus_err,
    output logic [N_HARTS-1:0] mtip,
    output logic [N_HARTS-1:0] msip
);

    localparam int unsigned MAP_WORDS = map_words(N_HARTS);

    logic [31:0]        a;
    logic [31:0]        hart_idx;
    hart_reg_e          hreg;
    logic               wr, rd, mapped, is_hart;
    logic               wr_presc, wr_ctrl, wr_mlo, wr_mhi, clr_presc, tick;
    logic [PRESC_W-1:0] presc, pcnt;
    logic               en;
    logic [63:0]        mtime;
    logic [31:0]        mtime_hi_rd;
    logic [31:0]        rd_mux;
    logic [31:0]        hart_or [N_HARTS+1];

    always_comb begin
        a         = 32'(addr);
        wr        = req & wr_H_rd_L;
        rd        = req & ~wr_H_rd_L;
        mapped    = a < MAP_WORDS;
        is_hart   = mapped & (a >= HART_BASE);
        hart_idx  = (a - HART_BASE) / HART_STRIDE;
        hreg      = hart_reg_e'(a[1:0]);
        wr_presc  = wr & (a == OFF_PRESC);
        wr_mlo    = wr & (a == OFF_MTIME_LO);
        wr_mhi    = wr & (a == OFF_MTIME_HI);
        wr_ctrl   = wr & (a == OFF_CTRL);
        clr_presc = wr_ctrl & wdata[CTRL_CLR_PRESC];
        // A reload (PRESCALER write or CLR_PRESC) takes precedence over a pending tick.
        tick      = en & (pcnt == '0) & ~wr_presc & ~clr_presc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            pcnt  <= '0;
            en    <= 1'b0;
            mtime <= '0;
        end else begin
            if (wr_presc) presc <= wdata[PRESC_W-1:0];
            if (wr_ctrl)  en    <= wdata[CTRL_EN];

            if (wr_presc)       pcnt <= wdata[PRESC_W-1:0];
            else if (clr_presc) pcnt <= presc;
            else if (tick)      pcnt <= presc;
            else if (en)        pcnt <= pcnt - PRESC_W'(1);

            if (wr_mlo)      mtime[31:0]  <= wdata;
            else if (wr_mhi) mtime[63:32] <= wdata;
            else if (tick)   mtime        <= mtime + 64'd1;
        end
    end

`ifdef CLINT_MTIME_SNAP_EN
    logic [31:0] snap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          snap <= '0;
        else if (rd && a == OFF_MTIME_LO)    snap <= mtime[63:32];
    end

    assign mtime_hi_rd = snap;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    assign hart_or[0] = '0;

    for (genvar g = 0; g < N_HARTS; g++) begin : g_hart
        logic        hit;
        logic [63:0] cmp;
        logic [31:0] hart_rd;

        assign hit = is_hart & (hart_idx == g);

        clint_hart_cmp u_cmp (
            .clk     (clk),
            .rst_n   (rst_n),
            .mtime   (mtime),
            .en      (en),
            .wr_lo   (wr & hit & (hreg == HREG_CMP_LO)),
            .wr_hi   (wr & hit & (hreg == HREG_CMP_HI)),
            .wr_msip (wr & hit & (hreg == HREG_MSIP)),
            .wdata   (wdata),
            .cmp     (cmp),
            .mtip    (mtip[g]),
            .msip    (msip[g])
        );

        always_comb begin
            hart_rd = '0;
            case (hreg)
                HREG_CMP_LO: hart_rd = cmp[31:0];
                HREG_CMP_HI: hart_rd = cmp[63:32];
                HREG_MSIP:   hart_rd = {31'b0, msip[g]};
                HREG_STATUS: hart_rd = {30'b0, msip[g], mtip[g]};
                default:     hart_rd = '0;
            endcase
        end

        assign hart_or[g+1] = hart_or[g] | (hit ? hart_rd : '0);
    end

    always_comb begin
        rd_mux = '0;
        if (a == OFF_PRESC)         rd_mux = 32'(presc);
        else if (a == OFF_MTIME_LO) rd_mux = mtime[31:0];
        else if (a == OFF_MTIME_HI) rd_mux = mtime_hi_rd;
        else if (a == OFF_CTRL)     rd_mux = {31'b0, en};
        else                        rd_mux = hart_or[N_HARTS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata   <= '0;
            rvalid  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            rvalid  <= rd;
            bus_err <= req & ~mapped;
            if (rd) rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_clint_mh.sv
// Self-checking bench for clint_mh (2 harts): vector table plus timed sequences, scoreboarded bus responses.
module tb_clint_mh;

    localparam int unsigned NH = 2;
    localparam int unsigned AW = 6;
    localparam int unsigned PW = 16;

    localparam logic [AW-1:0] A_PRESC = 6'd0;
    localparam logic [AW-1:0] A_LO    = 6'd1;
    localparam logic [AW-1:0] A_HI    = 6'd2;
    localparam logic [AW-1:0] A_CTRL  = 6'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_H_rd_L = 1'b0;
    logic          req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          bus_err;
    logic [NH-1:0] mtip;
    logic [NH-1:0] msip;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    clint_mh #(.N_HARTS(NH), .ADDR_W(AW), .PRESC_W(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_H_rd_L (wr_H_rd_L),
        .req       (req),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .bus_err   (bus_err),
        .mtip      (mtip),
        .msip      (msip)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          due;
        logic        rv;
        logic        err;
        logic [31:0] data;
    } sb_t;

    sb_t   sb_q[$];
    string nm_q[$];
    sb_t   sb_e;
    string sb_n;

    always @(negedge clk) begin
        if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            sb_e = sb_q.pop_front();
            sb_n = nm_q.pop_front();
            checks++;
            if (rvalid !== sb_e.rv || bus_err !== sb_e.err || (sb_e.rv && rdata !== sb_e.data)) begin
                errors++;
                $display("FAIL %s: got rvalid=%b bus_err=%b rdata=%h, want rvalid=%b bus_err=%b rdata=%h",
                         sb_n, rvalid, bus_err, rdata, sb_e.rv, sb_e.err, sb_e.data);
            end
        end else if (rst_n && (rvalid || bus_err)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got rvalid=%b bus_err=%b, want none", rvalid, bus_err);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input logic exp_err, input string name);
        sb_t e;
        if (!w || exp_err) begin
            e.due  = cyc + 1;
            e.rv   = ~w;
            e.err  = exp_err;
            e.data = exp;
            sb_q.push_back(e);
            nm_q.push_back(name);
        end
        req       = 1'b1;
        wr_H_rd_L = w;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        req       = 1'b0;
        wr_H_rd_L = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        access(1'b1, a, d, 32'h0, 1'b0, "wr");
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        access(1'b0, a, 32'h0, exp, 1'b0, name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [31:0]   exp;
        logic          err;
    } vec_t;

    vec_t tbl[22];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // reset map: CMP all-ones, everything else 0, unmapped reads 0 with bus_err
        tbl[0]  = '{1'b0, 6'd0,  32'h0, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 6'd1,  32'h0, 32'h0000_0000, 1'b0};
        tbl[2]  = '{1'b0, 6'd2,  32'h0, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b0, 6'd3,  32'h0, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b0, 6'd4,  32'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[5]  = '{1'b0, 6'd5,  32'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[6]  = '{1'b0, 6'd6,  32'h0, 32'h0000_0000, 1'b0};
        tbl[7]  = '{1'b0, 6'd7,  32'h0, 32'h0000_0000, 1'b0};
        tbl[8]  = '{1'b0, 6'd8,  32'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[9]  = '{1'b0, 6'd9,  32'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[10] = '{1'b0, 6'd10, 32'h0, 32'h0000_0000, 1'b0};
        tbl[11] = '{1'b0, 6'd11, 32'h0, 32'h0000_0000, 1'b0};
        tbl[12] = '{1'b0, 6'd12, 32'h0, 32'h0000_0000, 1'b1};
        tbl[13] = '{1'b0, 6'd63, 32'h0, 32'h0000_0000, 1'b1};
        // register write/readback, width masking, read-only STATUS, unmapped write
        tbl[14] = '{1'b1, 6'd13, 32'h1234_5678, 32'h0, 1'b1};
        tbl[15] = '{1'b1, 6'd4,  32'h1234_5678, 32'h0, 1'b0};
        tbl[16] = '{1'b0, 6'd4,  32'h0, 32'h1234_5678, 1'b0};
        tbl[17] = '{1'b1, 6'd4,  32'hFFFF_FFFF, 32'h0, 1'b0};
        tbl[18] = '{1'b1, 6'd0,  32'h000A_BCD5, 32'h0, 1'b0};
        tbl[19] = '{1'b0, 6'd0,  32'h0, 32'h0000_BCD5, 1'b0};
        tbl[20] = '{1'b1, 6'd0,  32'h0, 32'h0, 1'b0};
        tbl[21] = '{1'b1, 6'd7,  32'h3, 32'h0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_mtip", mtip, 0);
        chk("rst_msip", msip, 0);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 22; i++)
            access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp, tbl[i].err, $sformatf("vec%0d_a%0d", i, tbl[i].a));
        rd(6'd7, 32'h0, "status_ro");

        // prescaler 3: first tick 4 cycles after EN lands, then every 4
        wr(A_PRESC, 32'd3);
        wr(A_CTRL, 32'd1);
        rd(A_LO, 32'd0, "presc3_t0");
        idle(3);
        rd(A_LO, 32'd1, "presc3_t1");
        idle(2);
        rd(A_LO, 32'd1, "presc3_t1b");
        rd(A_LO, 32'd2, "presc3_t2");
        rd(A_CTRL, 32'd1, "ctrl_en");

        // prescaler 0: one increment per cycle
        wr(A_CTRL, 32'd0);
        wr(A_LO, 32'h100);
        wr(A_HI, 32'h0);
        wr(A_PRESC, 32'd0);
        wr(A_CTRL, 32'd1);
        rd(A_LO, 32'h100, "presc0_c0");
        rd(A_LO, 32'h101, "presc0_c1");
        rd(A_LO, 32'h102, "presc0_c2");

        // LO->HI carry and full 64-bit wrap
        wr(A_CTRL, 32'd0);
        wr(A_LO, 32'hFFFF_FFFE);
        wr(A_HI, 32'h0);
        wr(A_CTRL, 32'd1);
        idle(1);
        wr(A_CTRL, 32'd0);
        rd(A_LO, 32'h0, "carry_lo");
        rd(A_HI, 32'h1, "carry_hi");
        wr(A_LO, 32'hFFFF_FFFF);
        wr(A_HI, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'd1);
        wr(A_CTRL, 32'd0);
        rd(A_LO, 32'h0, "wrap_lo");
        rd(A_HI, 32'h0, "wrap_hi");

        // hart 1 compare at 0x10 with MTIME counting from 0
        wr(6'd9, 32'hFFFF_FFFF);
        wr(6'd8, 32'h10);
        wr(6'd9, 32'h0);
        wr(A_CTRL, 32'd1);
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("mtip_before", mtip, 2'b00);
        @(negedge clk);
        chk("mtip_rise", mtip, 2'b10);
        @(posedge clk);
        #1;
        wr(6'd8, 32'h100);
        @(negedge clk);
        chk("mtip_hold", mtip, 2'b10);
        @(negedge clk);
        chk("mtip_fall", mtip, 2'b00);
        @(posedge clk);
        #1;
        wr(6'd8, 32'h0);
        wr(A_CTRL, 32'd0);
        @(negedge clk);
        chk("mtip_cmp0", mtip, 2'b10);
        @(negedge clk);
        chk("mtip_en_off", mtip, 2'b00);
        @(posedge clk);
        #1;

        // software interrupt, STATUS, read-data hold, unmapped accesses
        chk("msip_pre", msip, 2'b00);
        wr(6'd6, 32'h1);
        @(negedge clk);
        chk("msip_set", msip, 2'b01);
        @(posedge clk);
        #1;
        rd(6'd7, 32'h2, "status0");
        rd(6'd6, 32'h1, "msip0_rd");
        idle(2);
        chk("rdata_hold", rdata, 32'h1);
        access(1'b0, 6'd12, 32'h0, 32'h0, 1'b1, "unmapped_rd");
        access(1'b1, 6'd40, 32'hDEAD_BEEF, 32'h0, 1'b1, "unmapped_wr");
        rd(6'd10, 32'h0, "msip1_rd");
        wr(6'd6, 32'h0);
        @(negedge clk);
        chk("msip_clr", msip, 2'b00);
        @(posedge clk);
        #1;

        // LO then HI read across a carry; MTIME_LO write on a tick cycle drops the increment
        wr(A_LO, 32'hFFFF_FFFF);
        wr(A_HI, 32'h1);
        wr(A_CTRL, 32'd1);
        rd(A_LO, 32'hFFFF_FFFF, "snap_lo");
`ifdef CLINT_MTIME_SNAP_EN
        rd(A_HI, 32'h1, "snap_hi");
`else
        rd(A_HI, 32'h2, "live_hi");
`endif
        wr(A_LO, 32'h55);
        wr(A_CTRL, 32'd0);
        rd(A_LO, 32'h56, "wr_on_tick_lo");
        rd(A_HI, 32'h2, "wr_on_tick_hi");

        idle(3);
        chk("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
